// File: rtl/cofre_controlador.sv
// Purpose : safe keypad access controller. Collects N_DIGITS keys, compares them with a
//           programmable code, opens the safe, counts failures, and locks the keypad out.
// Latency : every output is registered and reflects the state entered on the previous edge.
// Backpressure: none; one keypress is accepted per cycle with digito != 0.
// Ports   : clk, reset (sync, active-high) | digito[1:0] key (00 none, 01 A, 10 B, 11 C),
//           prog (reprogram request, honoured only while open) | led (open), erro (1-cycle
//           wrong-code pulse), bloqueado (lockout), programando (code being reprogrammed).
module cofre_controlador #(
  parameter int                    N_DIGITS     = 5,
  parameter logic [2*N_DIGITS-1:0] DEFAULT_CODE = 10'h39B,
  parameter int                    MAX_FAILS    = 3,
  parameter int                    OPEN_CYCLES  = 8,
  parameter int                    LOCK_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] digito,
  input  logic       prog,
  output logic       led,
  output logic       erro,
  output logic       bloqueado,
  output logic       programando
);

  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int CW   = $clog2(N_DIGITS + 1);
  localparam int BW   = 2 * (N_DIGITS - 1);  // history of the digits preceding the current one
  localparam int KW   = 2 * N_DIGITS;

  typedef enum logic [1:0] {
    S_ENTRY = 2'd0,
    S_OPEN  = 2'd1,
    S_PROG  = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [FW-1:0]   fails_q, fails_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [KW-1:0]   code_q, code_d;
  logic            led_q, erro_q, bloq_q, progr_q;
  logic            erro_d;

  logic            key;
  logic            last;
  logic [KW-1:0]   word;

  assign key  = (digito != 2'b00);
  assign last = (cnt_q == CW'(N_DIGITS - 1));
  // Full code as it would be if the current key completes the entry.
  assign word = {buf_q, digito};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    fails_d = fails_q;
    timer_d = timer_q;
    code_d  = code_q;
    erro_d  = 1'b0;

    case (state_q)
      S_ENTRY: begin
        if (key) begin
          buf_d = word[BW-1:0];
          if (last) begin
            cnt_d = '0;
            if (word == code_q) begin
              state_d = S_OPEN;
              timer_d = '0;
              fails_d = '0;
            end else begin
              erro_d = 1'b1;
              // The failure that reaches the limit locks out and restarts the count.
              if (fails_q == FW'(MAX_FAILS - 1)) begin
                state_d = S_LOCK;
                timer_d = '0;
                fails_d = '0;
              end else begin
                fails_d = fails_q + 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_OPEN: begin
        // A reprogram request takes priority over the open timer running out.
        if (prog) begin
          state_d = S_PROG;
          cnt_d   = '0;
        end else if (timer_q == TW'(OPEN_CYCLES - 1)) begin
          state_d = S_ENTRY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_PROG: begin
        if (key) begin
          buf_d = word[BW-1:0];
          if (last) begin
            cnt_d   = '0;
            code_d  = word;
            state_d = S_ENTRY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_LOCK: begin
        if (timer_q == TW'(LOCK_CYCLES - 1)) begin
          state_d = S_ENTRY;
          cnt_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = S_ENTRY;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ENTRY;
      cnt_q   <= '0;
      buf_q   <= '0;
      fails_q <= '0;
      timer_q <= '0;
      code_q  <= DEFAULT_CODE;
      led_q   <= 1'b0;
      erro_q  <= 1'b0;
      bloq_q  <= 1'b0;
      progr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      fails_q <= fails_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      // Outputs are decoded from the next state so they line up with it.
      led_q   <= (state_d == S_OPEN) || (state_d == S_PROG);
      erro_q  <= erro_d;
      bloq_q  <= (state_d == S_LOCK);
      progr_q <= (state_d == S_PROG);
    end
  end

  assign led         = led_q;
  assign erro        = erro_q;
  assign bloqueado   = bloq_q;
  assign programando = progr_q;

endmodule
